// File: rtl/multicycle_control.sv
// Control FSM for the multicycle MIPS datapath.
// Steps through fetch / decode / execute / memory / write-back and drives every
// datapath select and enable. The shared memory port uses a ready handshake; a
// port that stays not-ready for TIMEOUT consecutive cycles traps to ERROR.
// Outputs are decoded from the current state, qualified by mem_ready, zero and opcode.
module multicycle_control #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       mem_error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXEC = 4'd6,
        RTWB   = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11,
        ERROR  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_error_q, mem_error_d;
    logic             in_mem_state;
    logic             timeout_hit;

    // State, wait counter and sticky error flag; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    // Next-state logic; a memory timeout overrides the normal stall (ready wins on the last cycle).
    always_comb begin
        state_d      = state_q;
        mem_error_d  = mem_error_q;
        in_mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
        wait_cnt_d   = (in_mem_state && !mem_ready) ? wait_cnt_q + CNT_W'(1) : '0;
        timeout_hit  = (TIMEOUT != 0) && in_mem_state && !mem_ready && (wait_cnt_q == WAIT_LIMIT);

        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:       state_d = RTEXEC;
                    OP_LW, OP_SW:   state_d = MEMADR;
                    OP_BEQ:         state_d = BRANCH;
                    OP_ADDI, OP_ORI: state_d = IEXEC;
                    OP_J:           state_d = JUMP;
                    default:        state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (mem_ready) state_d = FETCH;
            RTEXEC: state_d = RTWB;
            RTWB:   state_d = FETCH;
            BRANCH: state_d = FETCH;
            IEXEC:  state_d = IWB;
            IWB:    state_d = FETCH;
            JUMP:   state_d = FETCH;
            ERROR:  state_d = ERROR;
            default: state_d = FETCH;
        endcase

        if (timeout_hit) begin
            state_d     = ERROR;
            mem_error_d = 1'b1;
            wait_cnt_d  = '0;
        end
    end

    // Output decode; ir_write/pc_en in FETCH only fire on a completed read and never during reset.
    always_comb begin
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready && !reset;
                pc_en     = mem_ready && !reset;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            RTEXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            RTWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_ORI) ? 2'b11 : 2'b00;
            end
            IWB: reg_write = 1'b1;
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mem_error = mem_error_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: inputs change on the falling edge and
// outputs are sampled 1 time unit later, so each check sees one FSM cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b001000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, illegal_op, mem_error;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .pc_en(pc_en), .illegal_op(illegal_op), .mem_error(mem_error), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    // Reset held for three cycles shows FETCH values with ir_write/pc_en suppressed.
    task automatic test_reset;
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b001000;
        repeat (3) tick();
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (ir_write !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL reset_gate got ir_write=%b pc_en=%b want 0 0", ir_write, pc_en); end
        checks++; if (mem_read !== 1'b1 || alu_src_b !== 2'b01) begin errors++; $display("FAIL reset_fetch_outs got mem_read=%b alu_src_b=%b want 1 01", mem_read, alu_src_b); end
        checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL reset_mem_error got %b want 0", mem_error); end
        tick();
        reset = 1'b0;
        $display("reset: released after 3 held cycles");
    endtask

    // addi / ori: FETCH, DECODE, IEXEC, IWB, FETCH.
    task automatic test_itype(input logic [5:0] op, input logic [1:0] exp_alu_op, input string nm);
        int seq [5] = '{0, 1, 9, 10, 0};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            mem_ready = 1'b1; opcode = op; zero = 1'b0;
            #1;
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL %s_state[%0d] got %0d want %0d", nm, i, state, seq[i]); end
            checks++; if (reg_write !== (seq[i] == 10)) begin errors++; $display("FAIL %s_reg_write[%0d] got %b want %b", nm, i, reg_write, seq[i] == 10); end
            if (seq[i] == 9) begin
                checks++; if (alu_op !== exp_alu_op || alu_src_b !== 2'b10 || alu_src_a !== 1'b1) begin errors++; $display("FAIL %s_iexec got alu_op=%b src_b=%b src_a=%b want %b 10 1", nm, alu_op, alu_src_b, alu_src_a, exp_alu_op); end
            end
        end
        $display("%s: opcode %b completed", nm, op);
    endtask

    // lw with two not-ready cycles in MEMRD.
    task automatic test_lw_stall;
        int seq [8] = '{0, 1, 2, 3, 3, 3, 4, 0};
        bit rdy [8] = '{1, 1, 1, 0, 0, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            mem_ready = rdy[i]; opcode = 6'b100011;
            #1;
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, seq[i]); end
            if (seq[i] == 3) begin
                checks++; if (mem_read !== 1'b1 || iord !== 1'b1) begin errors++; $display("FAIL lw_memrd[%0d] got mem_read=%b iord=%b want 1 1", i, mem_read, iord); end
            end
            if (seq[i] == 4) begin
                checks++; if (mem_to_reg !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin errors++; $display("FAIL lw_memwb got mem_to_reg=%b reg_write=%b reg_dst=%b want 1 1 0", mem_to_reg, reg_write, reg_dst); end
            end
        end
        $display("lw: 2 wait cycles, completed");
    endtask

    // sw with one not-ready cycle in MEMWR.
    task automatic test_sw_stall;
        int seq [6] = '{0, 1, 2, 5, 5, 0};
        bit rdy [6] = '{1, 1, 1, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            mem_ready = rdy[i]; opcode = 6'b101011;
            #1;
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state, seq[i]); end
            if (seq[i] == 5) begin
                checks++; if (mem_write !== 1'b1 || iord !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL sw_memwr[%0d] got mem_write=%b iord=%b mem_read=%b want 1 1 0", i, mem_write, iord, mem_read); end
            end
            if (seq[i] == 2) begin
                checks++; if (alu_src_b !== 2'b10 || alu_src_a !== 1'b1 || alu_op !== 2'b00) begin errors++; $display("FAIL sw_memadr got src_b=%b src_a=%b alu_op=%b want 10 1 00", alu_src_b, alu_src_a, alu_op); end
            end
        end
        $display("sw: 1 wait cycle, completed");
    endtask

    // beq, taken or not depending on zero.
    task automatic test_beq(input logic z);
        int seq [4] = '{0, 1, 8, 0};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            mem_ready = 1'b1; opcode = 6'b000100; zero = z;
            #1;
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL beq%0b_state[%0d] got %0d want %0d", z, i, state, seq[i]); end
            if (seq[i] == 8) begin
                checks++; if (pc_en !== z || pc_src !== 2'b01 || alu_op !== 2'b01) begin errors++; $display("FAIL beq%0b_branch got pc_en=%b pc_src=%b alu_op=%b want %b 01 01", z, pc_en, pc_src, alu_op, z); end
            end
        end
        zero = 1'b0;
        $display("beq: zero=%0b completed", z);
    endtask

    // Illegal opcode acts as a NOP, then a jump follows.
    task automatic test_illegal_then_jump;
        int seq [6] = '{0, 1, 0, 1, 11, 0};
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            mem_ready = 1'b1; opcode = (i < 2) ? 6'b111111 : 6'b000010;
            #1;
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL illj_state[%0d] got %0d want %0d", i, state, seq[i]); end
            checks++; if (illegal_op !== (i == 1)) begin errors++; $display("FAIL illj_illegal_op[%0d] got %b want %b", i, illegal_op, i == 1); end
            checks++; if (reg_write !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL illj_writes[%0d] got reg_write=%b mem_write=%b want 0 0", i, reg_write, mem_write); end
            if (seq[i] == 1) begin
                checks++; if (pc_en !== 1'b0 || alu_src_b !== 2'b11) begin errors++; $display("FAIL illj_decode[%0d] got pc_en=%b src_b=%b want 0 11", i, pc_en, alu_src_b); end
            end
            if (seq[i] == 11) begin
                checks++; if (pc_en !== 1'b1 || pc_src !== 2'b10) begin errors++; $display("FAIL illj_jump got pc_en=%b pc_src=%b want 1 10", pc_en, pc_src); end
            end
        end
        $display("illegal+j: illegal skipped, jump completed");
    endtask

    // Asynchronous reset while sw is stalled in MEMWR.
    task automatic test_async_reset;
        int seq [4] = '{0, 1, 2, 5};
        bit rdy [4] = '{1, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            mem_ready = rdy[i]; opcode = 6'b101011;
            #1;
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL areset_state[%0d] got %0d want %0d", i, state, seq[i]); end
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (state !== 4'd0 || mem_write !== 1'b0 || iord !== 1'b0) begin errors++; $display("FAIL areset_immediate got state=%0d mem_write=%b iord=%b want 0 0 0", state, mem_write, iord); end
        checks++; if (mem_read !== 1'b1 || ir_write !== 1'b0) begin errors++; $display("FAIL areset_fetch got mem_read=%b ir_write=%b want 1 0", mem_read, ir_write); end
        tick();
        reset = 1'b0;
        $display("async reset: sw aborted in MEMWR");
    endtask

    // Four stall cycles in FETCH trap; then ready on the fourth stall cycle wins.
    task automatic test_timeout;
        int seq [6] = '{0, 0, 0, 0, 15, 15};
        bit rdy [6] = '{0, 0, 0, 0, 0, 1};
        int seq2 [8] = '{0, 0, 0, 0, 1, 6, 7, 0};
        bit rdy2 [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            mem_ready = rdy[i]; opcode = 6'b000000;
            #1;
            checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL tmo_state[%0d] got %0d want %0d", i, state, seq[i]); end
            checks++; if (mem_error !== (i >= 4)) begin errors++; $display("FAIL tmo_mem_error[%0d] got %b want %b", i, mem_error, i >= 4); end
            checks++; if (mem_read !== (i < 4) || ir_write !== 1'b0) begin errors++; $display("FAIL tmo_outs[%0d] got mem_read=%b ir_write=%b want %b 0", i, mem_read, ir_write, i < 4); end
        end
        tick();
        reset = 1'b1;
        #1;
        checks++; if (state !== 4'd0 || mem_error !== 1'b0) begin errors++; $display("FAIL tmo_reset got state=%0d mem_error=%b want 0 0", state, mem_error); end
        tick();
        reset = 1'b0;
        $display("timeout: ERROR entered and cleared by reset");
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            mem_ready = rdy2[i]; opcode = 6'b000000;
            #1;
            checks++; if (state !== 4'(seq2[i])) begin errors++; $display("FAIL tmo2_state[%0d] got %0d want %0d", i, state, seq2[i]); end
            checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL tmo2_mem_error[%0d] got %b want 0", i, mem_error); end
            if (i < 4) begin
                checks++; if (ir_write !== rdy2[i]) begin errors++; $display("FAIL tmo2_ir_write[%0d] got %b want %b", i, ir_write, rdy2[i]); end
            end
            if (seq2[i] == 6) begin
                checks++; if (alu_op !== 2'b10 || alu_src_b !== 2'b00 || alu_src_a !== 1'b1) begin errors++; $display("FAIL tmo2_rtexec got alu_op=%b src_b=%b src_a=%b want 10 00 1", alu_op, alu_src_b, alu_src_a); end
            end
            if (seq2[i] == 7) begin
                checks++; if (reg_dst !== 1'b1 || reg_write !== 1'b1) begin errors++; $display("FAIL tmo2_rtwb got reg_dst=%b reg_write=%b want 1 1", reg_dst, reg_write); end
            end
        end
        $display("late ready: R-type completed after 3 wait cycles");
    endtask

    initial begin
        test_reset();
        test_itype(6'b001000, 2'b00, "addi");
        test_itype(6'b001101, 2'b11, "ori");
        test_lw_stall();
        test_sw_stall();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal_then_jump();
        test_async_reset();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
